bpsk_mod: RTL and testbench
===========================

Name: bpsk_mod

Overview:
- Consumes the 1-bit PN data stream produced by the upstream bit source.
- Holds each data bit for one symbol period and multiplies it onto a LUT-generated sine carrier, producing signed BPSK samples for the simulation DAC/analysis path.
- Sits directly downstream of the bit stream stage, on the same clock.

Parameters:
- DATA_W, 12, output sample width (signed two's complement).
- PHASE_W, 5, sine LUT address width; LUT has 2^PHASE_W entries covering one carrier period.
- PHASE_INC, 4, phase accumulator step per enabled clock. Default gives 8 samples per carrier cycle.
- SPS, 32, enabled clocks per symbol; legal range 2..65535.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, sample enable; the symbol counter and phase advance only when en=1.
- bit_in, input, 1, data bit from the upstream bit stream; sampled only at symbol start.
- bit_ack, output, 1, one-cycle pulse in the cycle bit_in is captured.
- dout, output, DATA_W, signed BPSK sample.
- dout_valid, output, 1, dout carries a new sample this cycle.
- sym_start, output, 1, high with the first valid sample of each symbol.

Behaviour:
- Reset (rst=1 at an edge):
  - Clears sym_cnt, phase, sym_bit and all pipeline registers.
  - Outputs after reset: dout=0, dout_valid=0, bit_ack=0, sym_start=0.
  - The first enabled cycle after reset is a symbol start.
- Reset mid-symbol: discards the in-flight symbol and both pipeline stages with no partial output; the next enabled cycle starts a new symbol.
- Stage 0 (en=1):
  - If sym_cnt==0: capture sym_bit<=bit_in, set phase<=0, assert bit_ack for this cycle.
  - Otherwise: phase<=phase+PHASE_INC, wrapping modulo 2^PHASE_W.
  - sym_cnt<=(sym_cnt==SPS-1)?0:sym_cnt+1.
  - Phase resets to 0 at every symbol start; the carrier is symbol-coherent.
- Stage 0 (en=0): sym_cnt, phase and sym_bit hold; bit_ack=0.
- Stage 1: registered LUT read, LUT[k]=round((2^(DATA_W-1)-1)*sin(2*pi*k/2^PHASE_W)). Max magnitude is 2^(DATA_W-1)-1, so negation never overflows.
- Stage 2:
  - dout<= sym_bit ? LUT : -LUT. Bit 1 gives +carrier (0 deg); bit 0 gives inverted carrier (180 deg).
  - sym_bit is pipelined alongside the phase.
- Latency:
  - A stage-0 cycle with en=1 produces dout_valid=1 exactly 2 clocks later.
  - Pipeline stages advance every clock; valid is en delayed by 2.
  - sym_start is the stage-0 symbol-start flag delayed by 2.
- en=0 gaps: dout holds its last value with dout_valid=0. Gaps of any length do not alter the per-symbol sample sequence.
- Symbol boundary: the sample with sym_cnt==SPS-1 is immediately followed by phase 0 of the next symbol (phase discontinuity allowed). No extra or dropped samples.
- bit_in changes mid-symbol are ignored.
- Simultaneous rst and en: rst wins.

Test Plan:
- Reset check: rst=1 for 3 cycles, then en=1, bit_in=1 -> bit_ack on the first cycle after reset. Two cycles later: dout_valid=1, sym_start=1, dout=0. Then 1447, 2047, 1447, 0, -1447, -2047, -1447 repeating for 32 samples.
- Phase inversion: bit_in=0 at the second symbol start -> samples 32..39 are 0, -1447, -2047, -1447, 0, 1447, 2047, 1447. bit_ack pulses exactly every 32 enabled cycles.
- Mid-symbol bit change: toggle bit_in every cycle with en=1 -> each 32-sample symbol uses only the value present at its bit_ack cycle. Compare against a golden model driven by the upstream PN bits.
- Enable gating: en=1,0,0,1 pattern over 100 cycles -> dout_valid mirrors en delayed by 2. The valid-sample sequence is identical to the continuous-en run, and dout holds during gaps.
- Reset mid-operation: assert rst at sym_cnt=17 for 1 cycle -> dout_valid=0 for the next 2 cycles. The following valid sample has sym_start=1 and dout=0.
- Parameter sweep: SPS=2, PHASE_INC=8 -> samples alternate 0, 2047 for bit 1 and 0, -2047 for bit 0. bit_ack asserts every other enabled cycle.

Source files
------------

// File: rtl/bpsk_mod.sv
// BPSK modulator: holds one data bit per symbol and multiplies it onto a
// symbol-coherent sine carrier read from a ROM, two clocks of latency.
module bpsk_mod #(
  parameter int DATA_W    = 12,
  parameter int PHASE_W   = 5,
  parameter int PHASE_INC = 4,
  parameter int SPS       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     bit_in,
  output logic                     bit_ack,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     sym_start
);

  localparam int                 LUT_N    = 2 ** PHASE_W;
  localparam logic [15:0]        SPS_LAST = 16'(SPS - 1);
  localparam logic [PHASE_W-1:0] STEP     = PHASE_W'(PHASE_INC);

  // Rounded sine sample for table entry k; amplitude leaves headroom for negation.
  function automatic logic signed [DATA_W-1:0] sine_val(input int k);
    real amp;
    real s;
    int  r;
    amp = real'((2 ** (DATA_W - 1)) - 1);
    s   = amp * $sin(6.283185307179586 * real'(k) / real'(LUT_N));
    r   = (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
    return r[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] lut [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      assign lut[gi] = sine_val(gi);
    end
  endgenerate

  logic [15:0]              sym_cnt_reg;
  logic [PHASE_W-1:0]       phase_reg;
  logic                     sym_bit_reg;
  logic signed [DATA_W-1:0] lut_reg;
  logic                     bit_p1_reg;
  logic                     valid_p1_reg;
  logic                     start_p1_reg;

  logic                     sym_first;
  logic [PHASE_W-1:0]       phase_next;
  logic                     bit_next;
  logic [15:0]              cnt_next;

  assign sym_first  = (sym_cnt_reg == 16'd0);
  assign phase_next = sym_first ? '0 : phase_reg + STEP;
  assign bit_next   = sym_first ? bit_in : sym_bit_reg;
  assign cnt_next   = (sym_cnt_reg == SPS_LAST) ? 16'd0 : sym_cnt_reg + 16'd1;
  assign bit_ack    = en & ~rst & sym_first;

  // The ROM is addressed with the next phase so the read register doubles
  // as the first pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_reg  <= '0;
      phase_reg    <= '0;
      sym_bit_reg  <= 1'b0;
      lut_reg      <= '0;
      bit_p1_reg   <= 1'b0;
      valid_p1_reg <= 1'b0;
      start_p1_reg <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      sym_start    <= 1'b0;
    end else begin
      if (en) begin
        sym_cnt_reg <= cnt_next;
        phase_reg   <= phase_next;
        sym_bit_reg <= bit_next;
        lut_reg     <= lut[phase_next];
        bit_p1_reg  <= bit_next;
      end
      valid_p1_reg <= en;
      start_p1_reg <= en & sym_first;
      dout_valid   <= valid_p1_reg;
      sym_start    <= start_p1_reg;
      if (valid_p1_reg) begin
        dout <= bit_p1_reg ? lut_reg : -lut_reg;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_mod.sv
// Scoreboard bench for bpsk_mod: default instance plus an SPS=2/PHASE_INC=8
// instance, both driven by the same PN-derived bit stream.
module tb_bpsk_mod;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic bit_in = 1'b0;
  logic ack0, ack1, dv0, dv1, ss0, ss1;
  logic signed [11:0] d0, d1;

  always #5 clk = ~clk;

  bpsk_mod u0 (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in),
    .bit_ack(ack0), .dout(d0), .dout_valid(dv0), .sym_start(ss0)
  );

  bpsk_mod #(.SPS(2), .PHASE_INC(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .bit_in(bit_in),
    .bit_ack(ack1), .dout(d1), .dout_valid(dv1), .sym_start(ss1)
  );

  typedef struct {
    int cyc;
    int val;
    bit ss;
    int sym;
    int k;
  } item_t;

  item_t q0[$];
  item_t q1[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int idx[2]  = '{0, 0};
  int sym[2]  = '{-1, -1};
  bit mbit[2] = '{1'b0, 1'b0};
  bit exp_ack[2] = '{1'b0, 1'b0};
  int last[2] = '{0, 0};
  int sps[2]  = '{32, 2};
  int inc[2]  = '{4, 8};
  int lit[8]  = '{0, 1447, 2047, 1447, 0, -1447, -2047, -1447};
  logic [6:0] lfsr = 7'h5A;
  bit rst_seen;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Carrier sample k of a symbol: full-scale sine at k*INC/32 of a period.
  function automatic int ref_sample(int inst, int k, bit b);
    real s;
    int  r;
    s = 2047.0 * $sin(6.283185307179586 * real'((k * inc[inst]) % 32) / 32.0);
    r = (s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5);
    return b ? r : -r;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit pn_next();
    lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    return lfsr[0];
  endfunction

  // Symbol-start bits come from the PN source (first two forced 1, 0);
  // mid-symbol bits are random noise that must be ignored.
  function automatic bit bitsel();
    if (idx[0] != 0) return 1'($urandom_range(1, 0));
    if (sym[0] + 1 == 0) return 1'b1;
    if (sym[0] + 1 == 1) return 1'b0;
    return pn_next();
  endfunction

  task automatic model_issue(int inst, bit r, bit e, bit b);
    item_t it;
    exp_ack[inst] = 1'b0;
    if (r) begin
      idx[inst] = 0;
      if (inst == 0) begin
        while (q0.size() > 0 && q0[$].cyc >= cyc - 1) void'(q0.pop_back());
      end else begin
        while (q1.size() > 0 && q1[$].cyc >= cyc - 1) void'(q1.pop_back());
      end
    end else if (e) begin
      if (idx[inst] == 0) begin
        mbit[inst]    = b;
        sym[inst]     = sym[inst] + 1;
        exp_ack[inst] = 1'b1;
      end
      it.cyc = cyc;
      it.val = ref_sample(inst, idx[inst], mbit[inst]);
      it.ss  = (idx[inst] == 0);
      it.sym = sym[inst];
      it.k   = idx[inst];
      if (inst == 0) q0.push_back(it);
      else q1.push_back(it);
      idx[inst] = (idx[inst] + 1) % sps[inst];
    end
  endtask

  task automatic step(bit r, bit e, bit b);
    @(posedge clk);
    #1;
    rst    = r;
    en     = e;
    bit_in = b;
    model_issue(0, r, e, b);
    model_issue(1, r, e, b);
  endtask

  task automatic mon(int inst, logic v, logic signed [11:0] d, logic s);
    item_t it;
    int    qs;
    qs = (inst == 0) ? q0.size() : q1.size();
    if (v) begin
      if (qs == 0) begin
        check($sformatf("spurious_valid%0d", inst), 1, 0);
      end else begin
        it = (inst == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("latency%0d", inst), cyc - it.cyc, 2);
        check($sformatf("dout%0d", inst), int'(d), it.val);
        check($sformatf("sym_start%0d", inst), int'(s), int'(it.ss));
        if (inst == 0 && it.sym == 0)
          check("first_symbol_table", int'(d), lit[it.k % 8]);
      end
      last[inst] = int'(d);
    end else begin
      check($sformatf("hold%0d", inst), int'(d), last[inst]);
      if (qs > 0) begin
        it = (inst == 0) ? q0[0] : q1[0];
        if (it.cyc <= cyc - 2) check($sformatf("missing_sample%0d", inst), 0, 1);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("bit_ack0", int'(ack0), int'(exp_ack[0]));
      check("bit_ack1", int'(ack1), int'(exp_ack[1]));
      if (rst_seen) begin
        check("rst_valid0", int'(dv0), 0);
        check("rst_dout0", int'(d0), 0);
        check("rst_start0", int'(ss0), 0);
        check("rst_valid1", int'(dv1), 0);
        check("rst_dout1", int'(d1), 0);
        last[0] = 0;
        last[1] = 0;
      end else begin
        mon(0, dv0, d0, ss0);
        mon(1, dv1, d1, ss1);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b1);
    // Continuous enable, two symbols with noisy mid-symbol bits.
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, bitsel());
    // Enable gating 1,0,0,1.
    for (int i = 0; i < 100; i++) step(1'b0, (i % 4 == 0) || (i % 4 == 3), bitsel());
    // Reset at sym_cnt 17, issued together with en so reset must win.
    for (int i = 0; i < 64 && idx[0] != 17; i++) step(1'b0, 1'b1, bitsel());
    step(1'b1, 1'b1, bitsel());
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, bitsel());
    // Randomized enable with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(96, 0) == 0), ($urandom_range(3, 0) != 0), bitsel());
    repeat (4) step(1'b0, 1'b0, 1'b0);
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
